spi_reg_arbiter: RTL and testbench
==================================

SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, register address width.
REQ-002 Parameter DATA_W, default 8, register data width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_valid / b_valid  input  1  port A (SPI slave decoder) / port B (bridge FSM status writer) request.
REQ-006 a_ready / b_ready  output  1  request accepted this cycle.
REQ-007 a_we / b_we  input  1  1 = write, 0 = read.
REQ-008 a_addr / b_addr  input  ADDR_W  target register.
REQ-009 a_wdata / b_wdata  input  DATA_W  write data.
REQ-010 a_lock / b_lock  input  1  hold grant across consecutive accesses (burst).
REQ-011 a_rsp_valid / b_rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_W  read data, shared; valid only with a rsp_valid pulse.
REQ-013 bank_en, bank_we  output  1  register-bank strobe and write enable.
REQ-014 bank_addr  output  ADDR_W; bank_wdata  output  DATA_W; bank_rdata  input  DATA_W (valid one cycle after bank_en).

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with one access in flight at a time.
REQ-016 IDLE: if any valid is high, the arbiter SHALL latch the grant, addr, we and wdata, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both valid, the port not granted last wins; after reset, A wins the first tie.
REQ-018 ISSUE SHALL assert bank_en, the latched bank_we/addr/wdata and the granted port's ready for exactly one cycle, then go to WAIT.
REQ-019 WAIT SHALL capture bank_rdata into rsp_rdata and go to RESP.
REQ-020 RESP SHALL pulse the granted port's rsp_valid for one cycle (writes included), then go to IDLE.
REQ-021 Latency: valid seen in IDLE at cycle N gives ready at N+1 and rsp_valid at N+3; the next accept is no earlier than N+5.
REQ-022 Request inputs SHALL be sampled only in IDLE; a requester SHALL hold valid/addr/we/wdata stable until ready.
REQ-023 Dropping valid before ready SHALL be tolerated: a grant already latched still completes using the latched values.
REQ-024 rsp_rdata SHALL hold its last value outside RESP; its value after a write is don't-care.
REQ-025 All outputs SHALL be registered; bank_* SHALL be zero whenever bank_en is low.

Reset
REQ-026 Reset SHALL force state IDLE, the last-grant pointer to B (so A wins first), lock owner to none, and all outputs to 0.
REQ-027 Reset mid-access SHALL abandon the access with no rsp_valid; a bank write already strobed is not undone.

Configuration
REQ-028 With SPI_REG_ARB_LOCK_EN defined: if the granted port's lock is high in RESP, that port SHALL become lock owner and the other port SHALL not be granted until the owner is served with lock low or has valid low in IDLE.
REQ-029 Without SPI_REG_ARB_LOCK_EN: the lock ports SHALL remain present but be ignored, giving pure round-robin.

Structure
REQ-030 A shared package spi_reg_arb_pkg SHALL hold the FSM state enum, the port-ID enum (PORT_A, PORT_B) and the ADDR_W/DATA_W defaults.
REQ-031 The round-robin/lock grant logic SHALL be a sub-module spi_rr_grant2; the FSM and datapath stay in spi_reg_arbiter.

Verification
REQ-032 A-only write: addr 3, wdata 8'hA5 -> one bank_en with we=1, addr 3, data A5; a_ready at N+1; a_rsp_valid at N+3.
REQ-033 B-only read: addr 3, bank returns 8'hA5 -> b_rsp_valid at N+3 with rsp_rdata = A5; a_ready and a_rsp_valid never asserted.
REQ-034 Both held valid continuously for 4 accesses -> grant order A, B, A, B.
REQ-035 Lock (macro defined): A issues 3 reads with a_lock=1, then a 4th with a_lock=0, while B holds valid -> A, A, A, A, then B.
REQ-036 Reset asserted in WAIT -> no rsp_valid, state IDLE, next tie granted to A.
REQ-037 Same stimulus as REQ-035 with the macro undefined -> A, B, A, B, ... regardless of lock.

Source files
------------

// File: rtl/spi_reg_arb_pkg.sv
// spi_reg_arb_pkg: shared FSM state, port IDs and width defaults for the SPI register arbiter.
package spi_reg_arb_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/spi_rr_grant2.sv
// spi_rr_grant2: two-port round-robin grant with optional burst lock (SPI_REG_ARB_LOCK_EN).
module spi_rr_grant2
  import spi_reg_arb_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  a_valid,
  input  logic  b_valid,
  input  logic  a_lock,
  input  logic  b_lock,
  input  logic  sample,
  input  logic  done,
  input  port_t cur,
  output logic  req,
  output port_t gnt
);
  port_t last;
  port_t rr;
  assign req = a_valid | b_valid;
  assign rr  = (a_valid && b_valid) ? (last == PORT_A ? PORT_B : PORT_A) : (a_valid ? PORT_A : PORT_B);
  always_ff @(posedge clk) begin
    if (reset) last <= PORT_B;
    else if (sample && req) last <= gnt;
  end
`ifdef SPI_REG_ARB_LOCK_EN
  logic  held;
  port_t owner;
  logic  owner_valid;
  assign owner_valid = owner == PORT_A ? a_valid : b_valid;
  assign gnt = (held && owner_valid) ? owner : rr;
  // Ownership is decided at completion; an owner that walks away in IDLE releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      held  <= 1'b0;
      owner <= PORT_A;
    end else if (done) begin
      held  <= cur == PORT_A ? a_lock : b_lock;
      owner <= cur;
    end else if (sample && held && !owner_valid) begin
      held <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{a_lock, b_lock, done, cur};
  assign gnt = rr;
`endif
endmodule

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: arbitrates SPI decoder (A) and bridge FSM (B) onto one register bank; lock via SPI_REG_ARB_LOCK_EN.
module spi_reg_arbiter
  import spi_reg_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              b_valid,
  output logic              a_ready,
  output logic              b_ready,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              a_lock,
  input  logic              b_lock,
  output logic              a_rsp_valid,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bank_en,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata
);
  state_t state;
  port_t  cur;
  port_t  gnt;
  logic   req;
  spi_rr_grant2 u_grant (
    .clk    (clk),
    .reset  (reset),
    .a_valid(a_valid),
    .b_valid(b_valid),
    .a_lock (a_lock),
    .b_lock (b_lock),
    .sample (state == IDLE),
    .done   (state == RESP),
    .cur    (cur),
    .req    (req),
    .gnt    (gnt)
  );
  // Bank strobes are loaded on accept so they appear for exactly the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= PORT_A;
      a_ready     <= 1'b0;
      b_ready     <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      rsp_rdata   <= '0;
      bank_en     <= 1'b0;
      bank_we     <= 1'b0;
      bank_addr   <= '0;
      bank_wdata  <= '0;
    end else begin
      a_ready     <= 1'b0;
      b_ready     <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      bank_en     <= 1'b0;
      bank_we     <= 1'b0;
      bank_addr   <= '0;
      bank_wdata  <= '0;
      case (state)
        IDLE: if (req) begin
          state      <= ISSUE;
          cur        <= gnt;
          a_ready    <= gnt == PORT_A;
          b_ready    <= gnt == PORT_B;
          bank_en    <= 1'b1;
          bank_we    <= gnt == PORT_A ? a_we : b_we;
          bank_addr  <= gnt == PORT_A ? a_addr : b_addr;
          bank_wdata <= gnt == PORT_A ? a_wdata : b_wdata;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          state       <= RESP;
          rsp_rdata   <= bank_rdata;
          a_rsp_valid <= cur == PORT_A;
          b_rsp_valid <= cur == PORT_B;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter: directed checks of latency, round-robin, lock and reset behaviour.
module tb_spi_reg_arbiter;
  logic       clk = 0;
  logic       reset = 1;
  logic       a_valid = 0, b_valid = 0, a_we = 0, b_we = 0, a_lock = 0, b_lock = 0;
  logic [3:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [7:0] rsp_rdata, bank_wdata, bank_rdata;
  logic       bank_en, bank_we;
  logic [3:0] bank_addr;
  logic [7:0] mem [16];
  int n_chk = 0, n_fail = 0;
  int n_ar = 0, n_arsp = 0, n_brsp = 0;
  int gl[$];
  int ar0, arsp0;

  spi_reg_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata), .a_lock(a_lock), .b_lock(b_lock),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_en) begin
      if (bank_we) mem[bank_addr] <= bank_wdata;
      bank_rdata <= mem[bank_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (a_ready) gl.push_back(0);
    if (b_ready) gl.push_back(1);
    n_ar   += int'(a_ready);
    n_arsp += int'(a_rsp_valid);
    n_brsp += int'(b_rsp_valid);
  endtask

  initial begin
    repeat (3) tick;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_a_rsp", a_rsp_valid, 0);
    check("rst_b_rsp", b_rsp_valid, 0);
    check("rst_bank_en", bank_en, 0);
    check("rst_rdata", rsp_rdata, 0);
    reset = 0;
    tick;
    // A-only write
    a_valid = 1; a_we = 1; a_addr = 3; a_wdata = 8'hA5;
    tick;
    check("aw_ready", a_ready, 1);
    check("aw_b_ready", b_ready, 0);
    check("aw_bank", {bank_en, bank_we, bank_addr, bank_wdata}, {1'b1, 1'b1, 4'd3, 8'hA5});
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    tick;
    check("aw_bank_off", {bank_en, bank_we, bank_addr, bank_wdata}, 0);
    check("aw_ready_off", a_ready, 0);
    tick;
    check("aw_rsp", {a_rsp_valid, b_rsp_valid}, 2'b10);
    tick;
    check("aw_rsp_off", a_rsp_valid, 0);
    // B-only read of the value A wrote
    ar0 = n_ar; arsp0 = n_arsp;
    b_valid = 1; b_we = 0; b_addr = 3;
    tick;
    check("br_ready", b_ready, 1);
    check("br_bank", {bank_en, bank_we, bank_addr}, {1'b1, 1'b0, 4'd3});
    b_valid = 0; b_addr = 0;
    tick;
    tick;
    check("br_rsp", b_rsp_valid, 1);
    check("br_rdata", rsp_rdata, 8'hA5);
    tick;
    check("br_rsp_off", b_rsp_valid, 0);
    check("br_rdata_hold", rsp_rdata, 8'hA5);
    check("br_no_a", (n_ar - ar0) + (n_arsp - arsp0), 0);
    // Round-robin with both ports continuously valid
    gl.delete();
    a_valid = 1; b_valid = 1; a_addr = 1; b_addr = 2;
    for (int i = 0; i < 40 && gl.size() < 4; i++) tick;
    a_valid = 0; b_valid = 0;
    repeat (4) tick;
    check("rr_cnt", gl.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr%0d", i), gl[i], i % 2);
    // Lock burst from A while B waits
    gl.delete();
    ar0 = n_ar;
    a_valid = 1; b_valid = 1; a_lock = 1;
    for (int i = 0; i < 60 && gl.size() < 5; i++) begin
      tick;
      if (n_ar - ar0 == 4) begin a_lock = 0; a_valid = 0; end
    end
    a_valid = 0; b_valid = 0; a_lock = 0;
    repeat (4) tick;
    check("lk_cnt", gl.size(), 5);
    for (int i = 0; i < 5; i++) begin
`ifdef SPI_REG_ARB_LOCK_EN
      check($sformatf("lk%0d", i), gl[i], i == 4 ? 1 : 0);
`else
      check($sformatf("lk%0d", i), gl[i], i % 2);
`endif
    end
    // Reset during WAIT abandons the access and restores A-first priority
    a_valid = 1; a_we = 0; a_addr = 3;
    tick;
    check("rw_ready", a_ready, 1);
    a_valid = 0;
    tick;
    arsp0 = n_arsp;
    reset = 1;
    tick;
    check("rw_rsp_in_rst", a_rsp_valid, 0);
    check("rw_bank_in_rst", bank_en, 0);
    reset = 0;
    tick;
    tick;
    check("rw_no_rsp", n_arsp - arsp0, 0);
    a_valid = 1; b_valid = 1;
    tick;
    check("rw_tie", {a_ready, b_ready}, 2'b10);
    a_valid = 0; b_valid = 0;
    repeat (4) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
